// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side RAM with byte lanes plus MMIO cycle counter, scratch and TX FIFO
// Reads are combinational so a CPU load completes in the same cycle as its address.
module dmem_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [31:0]   r_cycle;
    logic [31:0]   r_scratch;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_mmio_hit;
    logic [1:0]    w_off;
    logic [AW-1:0] w_idx;
    logic          w_ram_we;
    logic          w_push_req;
    logic          w_ovf_clr;
    logic          w_scratch_we;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [31:0]   w_status;
    logic          w_unused_lsb;

    // Byte offset within the word never matters; lanes come only from dwe.
    assign w_unused_lsb = ^daddr[1:0];

    assign w_mmio_hit   = (daddr[31:4] == MMIO_BASE[31:4]);
    assign w_off        = daddr[3:2];
    assign w_idx        = daddr[AW+1:2];

    assign w_ram_we     = !reset && !w_mmio_hit;
    assign w_push_req   = !reset && w_mmio_hit && (w_off == 2'd1) && dwe[0];
    assign w_ovf_clr    = !reset && w_mmio_hit && (w_off == 2'd2) && dwe[0] && dwdata[2];
    assign w_scratch_we = !reset && w_mmio_hit && (w_off == 2'd3);

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && tx_ready;
    // A pop frees the slot in the same edge, so a full FIFO still accepts a concurrent push.
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    assign tx_valid = !w_empty;
    assign tx_data  = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (w_ram_we && dwe[n]) begin
                r_mem[w_idx][8*n +: 8] <= dwdata[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= dwdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle    <= '0;
            r_scratch  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            for (int n = 0; n < 4; n++) begin
                if (w_scratch_we && dwe[n]) begin
                    r_scratch[8*n +: 8] <= dwdata[8*n +: 8];
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_status = {24'd0, 4'(r_count), 1'b0, r_overflow, w_empty, w_full};

    always_comb begin
        drdata = r_mem[w_idx];
        if (w_mmio_hit) begin
            case (w_off)
                2'd0:    drdata = r_cycle;
                2'd1:    drdata = 32'd0;
                2'd2:    drdata = w_status;
                default: drdata = r_scratch;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder with a TX byte scoreboard
module tb_dmem_responder;

    localparam logic [31:0] MMIO    = 32'hFFFF_0000;
    localparam logic [31:0] CYCLE   = MMIO + 32'd0;
    localparam logic [31:0] TXDATA  = MMIO + 32'd4;
    localparam logic [31:0] STATUS  = MMIO + 32'd8;
    localparam logic [31:0] SCRATCH = MMIO + 32'd12;

    logic        clk;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int unsigned total;
    int unsigned bad;
    logic [7:0]  sb[$];

    dmem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        daddr  = a;
        dwdata = d;
        dwe    = we;
        tick();
        dwe    = 4'b0000;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        daddr = a;
        dwe   = 4'b0000;
        #1;
        chk(tag, drdata, exp);
    endtask

    // Every accepted byte leaving the FIFO must match the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                chk("tx_unexpected_pop", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                chk("tx_data", 32'(tx_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        daddr    = 32'd0;
        dwdata   = 32'd0;
        dwe      = 4'b0000;
        tx_ready = 1'b0;
        repeat (3) tick();

        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        rd_chk("rst_cycle", CYCLE, 32'd0);
        rd_chk("rst_status", STATUS, 32'h0000_0002);
        rd_chk("rst_scratch", SCRATCH, 32'd0);

        // Release reset: counter reads 0 this cycle, 1 next; writes to CYCLE are ignored
        reset = 1'b0;
        rd_chk("cycle_after_release", CYCLE, 32'd0);
        wr(CYCLE, 32'h0000_0100, 4'b1111);
        rd_chk("cycle_next", CYCLE, 32'd1);

        // RAM byte lanes and aliasing
        wr(32'h40, 32'h1122_3344, 4'b1111);
        wr(32'h40, 32'h00AA_0000, 4'b0100);
        rd_chk("ram_lane", 32'h40, 32'h11AA_3344);
        rd_chk("ram_alias", 32'h40 + 32'd4096, 32'h11AA_3344);
        rd_chk("ram_ignore_lsb", 32'h43, 32'h11AA_3344);

        // Read-during-write sees the old word
        wr(32'h44, 32'hA5A5_0001, 4'b1111);
        daddr  = 32'h44;
        dwdata = 32'h5A5A_0002;
        dwe    = 4'b1111;
        #1;
        chk("rdw_old", drdata, 32'hA5A5_0001);
        tick();
        dwe = 4'b0000;
        #1;
        chk("rdw_new", drdata, 32'h5A5A_0002);

        // Writes while reset is high are ignored
        wr(32'h80, 32'h1234_5678, 4'b1111);
        reset = 1'b1;
        wr(32'h80, 32'hDEAD_BEEF, 4'b1111);
        wr(SCRATCH, 32'hFFFF_FFFF, 4'b1111);
        reset = 1'b0;
        rd_chk("rst_gate_ram", 32'h80, 32'h1234_5678);
        rd_chk("rst_gate_scratch", SCRATCH, 32'd0);
        rd_chk("rst_gate_cycle0", CYCLE, 32'd0);
        tick();
        rd_chk("rst_gate_cycle1", CYCLE, 32'd1);

        // Scratch byte lanes, TXDATA reads zero
        wr(SCRATCH, 32'hAABB_CCDD, 4'b0101);
        rd_chk("scratch_lanes", SCRATCH, 32'h00BB_00DD);
        rd_chk("txdata_reads0", TXDATA, 32'd0);

        // Fill, overflow, clear, drain
        for (int i = 1; i <= 8; i++) begin
            wr(TXDATA, 32'(i), 4'b0001);
            sb.push_back(8'(i));
        end
        rd_chk("status_full", STATUS, 32'h0000_0081);
        wr(TXDATA, 32'h09, 4'b0001);
        rd_chk("status_ovf", STATUS, 32'h0000_0085);
        wr(STATUS, 32'h4, 4'b0001);
        rd_chk("status_ovf_clr", STATUS, 32'h0000_0081);
        tx_ready = 1'b1;
        repeat (8) tick();
        chk("drain_valid", 32'(tx_valid), 32'd0);
        chk("drain_sb_left", 32'(sb.size()), 32'd0);
        rd_chk("drain_status", STATUS, 32'h0000_0002);

        // Push and pop together while full
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(TXDATA, 32'h10 + 32'(i), 4'b0001);
            sb.push_back(8'h10 + 8'(i));
        end
        daddr    = TXDATA;
        dwdata   = 32'hAB;
        dwe      = 4'b0001;
        tx_ready = 1'b1;
        sb.push_back(8'hAB);
        tick();
        dwe      = 4'b0000;
        tx_ready = 1'b0;
        rd_chk("pushpop_full_status", STATUS, 32'h0000_0081);
        tx_ready = 1'b1;
        repeat (8) tick();
        chk("pushpop_drain_valid", 32'(tx_valid), 32'd0);
        chk("pushpop_sb_left", 32'(sb.size()), 32'd0);

        // Push latency into an empty FIFO
        daddr  = TXDATA;
        dwdata = 32'h5A;
        dwe    = 4'b0001;
        sb.push_back(8'h5A);
        #1;
        chk("lat_push_cycle_valid", 32'(tx_valid), 32'd0);
        tick();
        dwe = 4'b0000;
        chk("lat_next_valid", 32'(tx_valid), 32'd1);
        chk("lat_next_data", 32'(tx_data), 32'h5A);
        tick();
        chk("lat_popped_valid", 32'(tx_valid), 32'd0);
        wr(TXDATA, 32'h0000_7700, 4'b0010);
        chk("lane1_no_push_valid", 32'(tx_valid), 32'd0);
        rd_chk("lane1_no_push_status", STATUS, 32'h0000_0002);

        // Reset mid-stream discards queued bytes
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(TXDATA, 32'h31 + 32'(i), 4'b0001);
        end
        wr(SCRATCH, 32'hCAFE_F00D, 4'b1111);
        chk("mid_valid", 32'(tx_valid), 32'd1);
        rd_chk("mid_status", STATUS, 32'h0000_0030);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        rd_chk("mid_rst_status", STATUS, 32'h0000_0002);
        rd_chk("mid_rst_scratch", SCRATCH, 32'd0);
        rd_chk("mid_rst_ram40", 32'h40, 32'h11AA_3344);
        rd_chk("mid_rst_ram80", 32'h80, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
